// File: rtl/cadence_meas.sv
// Cadence period meter: counts prescale ticks between filtered cadence rises,
// reports the last period, a 4-deep running average and a not-pedaling flag.
module cadence_meas #(
   parameter bit FAST_SIM = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cadence_rise,
   input  logic       en,
   output logic [7:0] cadence_per,
   output logic       per_vld,
   output logic [7:0] cadence_avg,
   output logic       not_pedaling
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [15:0]     prescaler;
   logic [7:0]      per_cnt;
   logic [3:0][7:0] hist;
   logic [9:0]      hist_sum;
   logic            rise_acc;
   logic            tick;
   logic            timeout;
   logic            capture;
   logic            load_all;
   logic            flush;

   // A rise only counts while enabled; en low always wins over a coincident rise.
   assign rise_acc = cadence_rise & en;
   assign tick     = FAST_SIM ? (&prescaler[7:0]) : (&prescaler);
   assign timeout  = tick & (&per_cnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaler <= '0;
      end else if (rise_acc) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         per_cnt <= '0;
      end else if (rise_acc) begin
         per_cnt <= '0;
      end else if (tick && (per_cnt != 8'hFF)) begin
         per_cnt <= per_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (!en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (cadence_rise) state_nxt = ARM;
            ARM:     if (cadence_rise) state_nxt = RUN;
                     else if (timeout) state_nxt = IDLE;
            RUN:     if (cadence_rise) state_nxt = RUN;
                     else if (timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // A rise beats a coincident timeout, so a saturated per_cnt is captured as FF.
   always_comb begin
      capture      = 1'b0;
      load_all     = 1'b0;
      flush        = 1'b0;
      not_pedaling = (state == IDLE);
      if (en) begin
         case (state)
            ARM: begin
               capture  = cadence_rise;
               load_all = cadence_rise;
            end
            RUN: begin
               capture = cadence_rise;
               flush   = ~cadence_rise & timeout;
            end
            default: ;
         endcase
      end
   end

   // per_vld is a bare one-cycle strobe with no back-pressure: it marks the cycle
   // in which cadence_per and cadence_avg first show a new capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cadence_per <= 8'hFF;
         hist        <= {4{8'hFF}};
         per_vld     <= 1'b0;
      end else begin
         per_vld <= capture;
         if (capture) begin
            cadence_per <= per_cnt;
            if (load_all) begin
               hist <= {4{per_cnt}};
            end else begin
               hist <= {hist[2:0], per_cnt};
            end
         end else if (flush) begin
            cadence_per <= 8'hFF;
            hist        <= {4{8'hFF}};
         end
      end
   end

   assign hist_sum    = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, hist[3]};
   assign cadence_avg = hist_sum[9:2];

endmodule

// File: tb/tb_cadence_meas.sv
// Bench for cadence_meas (FAST_SIM=1): a bench-side period model feeds a
// scoreboard queue that is drained whenever per_vld strobes.
module tb_cadence_meas;

   logic       clk;
   logic       rst;
   logic       cadence_rise;
   logic       en;
   logic [7:0] cadence_per;
   logic       per_vld;
   logic [7:0] cadence_avg;
   logic       not_pedaling;

   int n_checks;
   int n_pass;
   int cyc;
   int last_rise;
   int m_state;
   logic [7:0] m_hist[4];
   logic [7:0] m_per;
   logic [15:0] exp_q[$];
   logic prev_vld;

   cadence_meas #(.FAST_SIM(1'b1)) dut (
      .clk         (clk),
      .rst         (rst),
      .cadence_rise(cadence_rise),
      .en          (en),
      .cadence_per (cadence_per),
      .per_vld     (per_vld),
      .cadence_avg (cadence_avg),
      .not_pedaling(not_pedaling)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Scoreboard: every per_vld strobe must match the oldest expected capture.
   always @(negedge clk) begin
      if (!rst) begin
         if (per_vld && prev_vld) check("vld_back_to_back", 1, 0);
         if (per_vld) begin
            if (exp_q.size() == 0) begin
               check("unexpected_vld", {24'd0, cadence_per}, 32'hDEAD);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               check("sb_per", cadence_per, e[15:8]);
               check("sb_avg", cadence_avg, e[7:0]);
            end
         end
      end
      prev_vld = per_vld;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_state = 0;
      m_per   = 8'hFF;
      for (int i = 0; i < 4; i++) m_hist[i] = 8'hFF;
   endtask

   task automatic drive_rise(input logic en_v);
      int s;
      int q;
      int sum;
      logic [7:0] p;
      en = en_v;
      cadence_rise = 1'b1;
      if (!en_v) begin
         m_state = 0;
      end else begin
         s = cyc - last_rise;
         last_rise = cyc;
         if (m_state == 0) begin
            m_state = 1;
         end else begin
            q = (s - 1) / 256;
            p = (q > 255) ? 8'hFF : 8'(q);
            if (m_state == 1) begin
               for (int i = 0; i < 4; i++) m_hist[i] = p;
            end else begin
               for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
               m_hist[0] = p;
            end
            m_per = p;
            m_state = 2;
            sum = 0;
            for (int i = 0; i < 4; i++) sum += int'(m_hist[i]);
            exp_q.push_back({p, 8'(sum / 4)});
         end
      end
      @(posedge clk);
      #1;
      cadence_rise = 1'b0;
      en = 1'b1;
   endtask

   initial begin
      int spacing[4];
      int n;
      n_checks = 0;
      n_pass = 0;
      cyc = 0;
      last_rise = 0;
      prev_vld = 1'b0;
      model_reset();
      rst = 1'b1;
      en = 1'b0;
      cadence_rise = 1'b0;

      #5;
      check("rst_per", cadence_per, 8'hFF);
      check("rst_avg", cadence_avg, 8'hFF);
      check("rst_vld", per_vld, 0);
      check("rst_np", not_pedaling, 1);

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      en = 1'b1;
      wait_cycles(3);

      // First rise arms, second measures 10 ticks.
      drive_rise(1'b1);
      check("arm_np", not_pedaling, 0);
      wait_cycles(2599);
      drive_rise(1'b1);
      check("first_vld", per_vld, 1);
      check("first_per", cadence_per, 8'd10);
      check("first_avg", cadence_avg, 8'd10);
      check("first_np", not_pedaling, 0);

      wait_cycles(2599);
      drive_rise(1'b1);
      wait_cycles(2599);
      drive_rise(1'b1);
      wait_cycles(3623);
      drive_rise(1'b1);
      check("seq_per", cadence_per, 8'd14);
      check("seq_avg", cadence_avg, 8'd11);

      // Rise coincident with the tick (256) and just after it (257), then random.
      spacing[0] = 256;
      spacing[1] = 257;
      spacing[2] = $urandom_range(300, 800);
      spacing[3] = $urandom_range(300, 800);
      for (int i = 0; i < 4; i++) begin
         wait_cycles(spacing[i] - 1);
         drive_rise(1'b1);
         check("rnd_per", cadence_per, m_per);
      end

      // en low on the rise cycle: no capture, back to idle, value held.
      wait_cycles(499);
      drive_rise(1'b0);
      wait_cycles(2);
      check("en_np", not_pedaling, 1);
      check("en_hold_per", cadence_per, m_per);

      // Reset mid-RUN discards the partial period.
      drive_rise(1'b1);
      wait_cycles(2599);
      drive_rise(1'b1);
      wait_cycles(1000);
      rst = 1'b1;
      #1;
      model_reset();
      check("mrst_per", cadence_per, 8'hFF);
      check("mrst_avg", cadence_avg, 8'hFF);
      check("mrst_np", not_pedaling, 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      wait_cycles(5);
      drive_rise(1'b1);
      check("mrst_arm_np", not_pedaling, 0);
      check("mrst_arm_per", cadence_per, 8'hFF);
      wait_cycles(2599);
      drive_rise(1'b1);
      check("mrst_per2", cadence_per, 8'd10);
      check("mrst_avg2", cadence_avg, 8'd10);

      // No more rises: timeout after 256 ticks of 256 clocks.
      n = 0;
      while (!not_pedaling && n < 70000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("to_cycles", n, 65536);
      check("to_np", not_pedaling, 1);
      check("to_per", cadence_per, 8'hFF);
      check("to_avg", cadence_avg, 8'hFF);

      wait_cycles(3);
      check("sb_drain", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
